// File: rtl/keypad_scanner.sv
// keypad_scanner: drives a 4x4 active-low keypad matrix column by column and reports one debounced key per press.
// Latency: key_valid/key_held rise one clock after the last row sample of the DEBOUNCE_SCANS-th matching scan.
// Backpressure: none; key_valid is a single-cycle pulse that the consumer must sample on every clock.
// Optional feature: define KEYPAD_REPEAT_EN to emit auto-repeat key_valid pulses while a key stays held.
module keypad_scanner #(
    parameter int PHASE_CYCLES   = 3,
    parameter int DEBOUNCE_SCANS = 2,
    parameter int REPEAT_SCANS   = 8
) (
    input  logic       clk_400Hz,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    // Phase counter width; PHASE_CYCLES must leave room for the 2-FF row synchronizer.
    localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYCLES - 1);

    // One width serves both the debounce and the repeat scan counters.
    localparam int SCAN_CNT_MAX = (REPEAT_SCANS > DEBOUNCE_SCANS) ? REPEAT_SCANS : DEBOUNCE_SCANS;
    localparam int CW = $clog2(SCAN_CNT_MAX + 1);
    localparam logic [CW-1:0] DEB_TGT = CW'(DEBOUNCE_SCANS);

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_HELD     = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SCAN_NONE  = 2'd0,
        SCAN_ONE   = 2'd1,
        SCAN_MULTI = 2'd2
    } scan_t;

    // Keypad legend: row r, column c -> hex label printed on the key.
    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'h1;
            4'h1:    k = 4'h2;
            4'h2:    k = 4'h3;
            4'h3:    k = 4'hA;
            4'h4:    k = 4'h4;
            4'h5:    k = 4'h5;
            4'h6:    k = 4'h6;
            4'h7:    k = 4'hB;
            4'h8:    k = 4'h7;
            4'h9:    k = 4'h8;
            4'hA:    k = 4'h9;
            4'hB:    k = 4'hC;
            4'hC:    k = 4'h0;
            4'hD:    k = 4'hF;
            4'hE:    k = 4'hE;
            4'hF:    k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    // Row synchronizer
    logic [3:0]      row_meta_q;
    logic [3:0]      row_sync_q;

    // Column scan timing
    logic [PW-1:0]   ph_q, ph_d;
    logic [1:0]      c_q, c_d;
    logic [3:0]      col_q, col_d;
    logic            sample_en;
    logic            scan_done;

    // Per-column row samples of the scan in progress (index = column)
    logic [3:0][3:0] samp_q;
    logic [3:0][3:0] scan_rows;

    // Scan classification
    logic [1:0]      hit_n;
    logic [3:0]      hit_code;
    scan_t           scan_res;

    // Debounce state
    state_t          state_q;
    logic [3:0]      cand_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   press_cnt;
    logic            held_match;

    // Registered outputs
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic            key_held_q;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CW-1:0] RPT_TGT = CW'(REPEAT_SCANS);
    logic [CW-1:0]   rpt_q;
    logic [CW-1:0]   rpt_inc;
`endif

    // Two-flop synchronizer; idle rows read high through the keypad pull-ups.
    always_ff @(posedge clk_400Hz or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // The last clock of a phase is the sample point; the last sample of column 3 closes a scan.
    assign sample_en = (ph_q == PH_LAST);
    assign scan_done = sample_en && (c_q == 2'd3);

    // Next phase/column; col is computed from the next column so the pin changes with c.
    always_comb begin
        ph_d = ph_q + PW'(1);
        c_d  = c_q;
        if (sample_en) begin
            ph_d = '0;
            c_d  = c_q + 2'd1;
        end
        col_d = ~(4'b0001 << c_d);
    end

    // Phase counter, column counter and registered active-low column drive.
    always_ff @(posedge clk_400Hz or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= '0;
            c_q   <= 2'd0;
            col_q <= 4'b1110;
        end else begin
            ph_q  <= ph_d;
            c_q   <= c_d;
            col_q <= col_d;
        end
    end

    // Capture the synchronized rows for the driven column at its sample point.
    always_ff @(posedge clk_400Hz or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '1;
        end else if (sample_en) begin
            samp_q[c_q] <= row_sync_q;
        end
    end

    // Full scan image: column 3 is taken live because its sample lands on the scan_done clock.
    always_comb begin
        scan_rows    = samp_q;
        scan_rows[3] = row_sync_q;
    end

    // Count pressed keys (saturating at 2) and remember the code of the last one found.
    always_comb begin
        hit_n    = 2'd0;
        hit_code = 4'h0;
        for (int ci = 0; ci < 4; ci++) begin
            for (int ri = 0; ri < 4; ri++) begin
                if (!scan_rows[ci][ri]) begin
                    if (hit_n != 2'd2) begin
                        hit_n = hit_n + 2'd1;
                    end
                    hit_code = key_lut(2'(ri), 2'(ci));
                end
            end
        end
        case (hit_n)
            2'd0:    scan_res = SCAN_NONE;
            2'd1:    scan_res = SCAN_ONE;
            default: scan_res = SCAN_MULTI;
        endcase
    end

    // Saturating counter increments and the press count for the current candidate.
    always_comb begin
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        press_cnt  = (hit_code == cand_q) ? cnt_inc : CW'(1);
        held_match = (scan_res == SCAN_ONE) && (hit_code == key_code_q);
    end

`ifdef KEYPAD_REPEAT_EN
    // Saturating increment of the auto-repeat scan counter.
    always_comb begin
        rpt_inc = (&rpt_q) ? rpt_q : rpt_q + CW'(1);
    end
`endif

    // Debounce FSM, stepped once per completed scan; outputs are registered here.
    always_ff @(posedge clk_400Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RELEASED;
            cand_q      <= 4'h0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (scan_done) begin
                case (state_q)
                    ST_RELEASED: begin
                        if (scan_res == SCAN_ONE) begin
                            cand_q <= hit_code;
                            if (press_cnt >= DEB_TGT) begin
                                state_q     <= ST_HELD;
                                key_code_q  <= hit_code;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                cnt_q       <= '0;
`ifdef KEYPAD_REPEAT_EN
                                rpt_q       <= '0;
`endif
                            end else begin
                                cnt_q <= press_cnt;
                            end
                        end else begin
                            // Nothing pressed, or a ghosting-prone multi-key image: start over.
                            cnt_q <= '0;
                        end
                    end
                    ST_HELD: begin
                        if (held_match) begin
                            cnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rpt_inc >= RPT_TGT) begin
                                key_valid_q <= 1'b1;
                                rpt_q       <= '0;
                            end else begin
                                rpt_q <= rpt_inc;
                            end
`endif
                        end else begin
                            // Any other image (none, other key, multi) counts toward release.
`ifdef KEYPAD_REPEAT_EN
                            rpt_q <= '0;
`endif
                            if (cnt_inc >= DEB_TGT) begin
                                state_q    <= ST_RELEASED;
                                key_held_q <= 1'b0;
                                cnt_q      <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_RELEASED;
                    end
                endcase
            end
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model answers the column drive with active-low rows.
// Timeline per test: reset is released on a falling edge, so rising edge n after release closes
// phase n/3; scan s ends at edge 12*(s+1) and key_valid/key_held changes are visible right after it.
module tb_keypad_scanner;

    logic        clk_400Hz = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] key_mask = '0;   // bit r*4+c = key at row r, column c held down
    int          edge_n   = 0;    // rising edges since reset release
    int          vld_cnt  = 0;    // key_valid pulses since reset release
    int          n_chk    = 0;
    int          n_pass   = 0;

    keypad_scanner dut (
        .clk_400Hz (clk_400Hz),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk_400Hz = ~clk_400Hz;

    // Keypad matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (key_mask[r*4 + c]) row[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk_400Hz or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    always @(negedge clk_400Hz) begin
        if (!rst_n)         vld_cnt <= 0;
        else if (key_valid) vld_cnt <= vld_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] one = 16'h0001;
        return one << (r*4 + c);
    endfunction

    function automatic logic [3:0] exp_col(input int n);
        logic [3:0] one = 4'b0001;
        return ~(one << ((n / 3) % 4));
    endfunction

    // Advance to the falling edge that follows rising edge e.
    task automatic run_to(input int e);
        int guard = 0;
        while (edge_n < e && guard < 2000) begin
            @(negedge clk_400Hz);
            guard++;
        end
        if (guard >= 2000) check("timeout", edge_n, e);
    endtask

    task automatic do_reset(input logic [15:0] m);
        @(negedge clk_400Hz);
        rst_n    = 1'b0;
        key_mask = m;
        @(negedge clk_400Hz);
        @(negedge clk_400Hz);
        rst_n = 1'b1;
    endtask

    initial begin
        int col_err;

        // ---- Test 1: reset values, idle scanning for 10 scans ----
        @(negedge clk_400Hz);
        @(negedge clk_400Hz);
        check("rst_col",   col,       4'b1110);
        check("rst_code",  key_code,  4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held",  key_held,  1'b0);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            run_to(n);
            check("t1_col", col, exp_col(n));
        end
        col_err = 0;
        for (int n = 12; n <= 120; n++) begin
            run_to(n);
            if (col !== exp_col(n)) col_err++;
        end
        check("t1_col_errs", col_err, 0);
        check("t1_vld_cnt",  vld_cnt, 0);
        check("t1_code",     key_code, 4'h0);

        // ---- Test 2: hold '5' (r1,c1) for 5 scans, then release ----
        do_reset(key_bit(1, 1));
        run_to(23);
        check("t2_valid_early", key_valid, 1'b0);
        check("t2_held_early",  key_held,  1'b0);
        run_to(24);
        check("t2_valid", key_valid, 1'b1);
        check("t2_code",  key_code,  4'h5);
        check("t2_held",  key_held,  1'b1);
        run_to(25);
        check("t2_valid_width", key_valid, 1'b0);
        check("t2_held_on",     key_held,  1'b1);
        run_to(60);
        key_mask = '0;
        run_to(83);
        check("t2_held_before_rel", key_held, 1'b1);
        run_to(84);
        check("t2_held_fall", key_held, 1'b0);
        check("t2_code_hold", key_code, 4'h5);
        run_to(100);
        check("t2_vld_cnt", vld_cnt, 1);

        // ---- Test 3: '9' (r2,c2) bouncing every other scan, then stable ----
        do_reset(key_bit(2, 2));
        for (int s = 1; s <= 6; s++) begin
            run_to(12 * s);
            key_mask = (s % 2 == 0) ? key_bit(2, 2) : 16'h0000;
        end
        check("t3_bounce_vld_cnt", vld_cnt, 0);
        check("t3_bounce_held",    key_held, 1'b0);
        run_to(95);
        check("t3_valid_early", key_valid, 1'b0);
        run_to(96);
        check("t3_valid", key_valid, 1'b1);
        check("t3_code",  key_code,  4'h9);
        run_to(108);
        check("t3_vld_cnt", vld_cnt, 1);

        // ---- Test 4: 'A' (r0,c3) and 'D' (r3,c3) together: ghosting guard ----
        do_reset(key_bit(0, 3) | key_bit(3, 3));
        run_to(24);
        check("t4_valid", key_valid, 1'b0);
        run_to(72);
        check("t4_vld_cnt", vld_cnt, 0);
        check("t4_held",    key_held, 1'b0);
        check("t4_code",    key_code, 4'h0);

        // ---- Test 5: '0' held, '1' added, '0' released; then reset mid-scan ----
        do_reset(key_bit(3, 0));
        run_to(24);
        check("t5_valid0", key_valid, 1'b1);
        check("t5_code0",  key_code,  4'h0);
        check("t5_held0",  key_held,  1'b1);
        run_to(36);
        key_mask = key_bit(3, 0) | key_bit(0, 0);
        run_to(48);
        key_mask = key_bit(0, 0);
        run_to(59);
        check("t5_held_multi", key_held, 1'b1);
        check("t5_code_multi", key_code, 4'h0);
        run_to(60);
        check("t5_held_rel", key_held, 1'b0);
        check("t5_vld_cnt",  vld_cnt, 1);
        run_to(72);
        check("t5_no_rollover", vld_cnt, 1);
        run_to(84);
        check("t5_valid1", key_valid, 1'b1);
        check("t5_code1",  key_code,  4'h1);
        run_to(89);
        @(posedge clk_400Hz);
        #2;
        check("t5_pre_col",  col,      4'b1011);
        check("t5_pre_held", key_held, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_arst_col",   col,       4'b1110);
        check("t5_arst_code",  key_code,  4'h0);
        check("t5_arst_valid", key_valid, 1'b0);
        check("t5_arst_held",  key_held,  1'b0);
        @(negedge clk_400Hz);
        rst_n = 1'b1;
        run_to(23);
        check("t5_redeb_early", key_valid, 1'b0);
        run_to(24);
        check("t5_redeb_valid", key_valid, 1'b1);
        check("t5_redeb_code",  key_code,  4'h1);

        // ---- Test 6: hold 'F' (r3,c1) for 20 scans ----
        do_reset(key_bit(3, 1));
        run_to(24);
        check("t6_valid", key_valid, 1'b1);
        check("t6_code",  key_code,  4'hF);
`ifdef KEYPAD_REPEAT_EN
        run_to(119);
        check("t6_rpt_early", key_valid, 1'b0);
        run_to(120);
        check("t6_rpt1", key_valid, 1'b1);
        run_to(215);
        check("t6_rpt_gap", vld_cnt, 2);
        run_to(216);
        check("t6_rpt2", key_valid, 1'b1);
        check("t6_rpt2_code", key_code, 4'hF);
        run_to(240);
        check("t6_vld_cnt", vld_cnt, 3);
`else
        run_to(120);
        check("t6_no_rpt", key_valid, 1'b0);
        run_to(240);
        check("t6_vld_cnt", vld_cnt, 1);
        check("t6_held",    key_held, 1'b1);
        check("t6_code_end", key_code, 4'hF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad (Pmod KYPD style: columns driven active-low, rows read active-low with pull-ups) and reports one debounced key code per press. It is the input-side counterpart of the display refresh logic: the same 400 Hz clock steps a column counter, but here the block samples returned rows instead of lighting digits. It sits between the keypad Pmod pins and the control FSM, which consumes `key_valid`/`key_code`.

## Interface
- `PHASE_CYCLES`, 3: clocks each column is driven; must be ≥3 because of the 2-FF row synchronizer.
- `DEBOUNCE_SCANS`, 2: consecutive identical full scans required to accept a press or a release.
- `REPEAT_SCANS`, 8: scans between auto-repeat pulses; used only with `KEYPAD_REPEAT_EN`.
- `clk_400Hz`  in  1  scan clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `row`  in  4  keypad rows, active-low, asynchronous to `clk_400Hz`.
- `col`  out  4  column drive, active-low one-hot.
- `key_code`  out  4  hex value of the accepted key; holds its value until the next accepted press.
- `key_valid`  out  1  one-cycle pulse when a press is accepted, or on a repeat.
- `key_held`  out  1  high while the accepted key is debounced-pressed.

## Operation
- Rows pass through a 2-FF synchronizer with reset value 4'hF.
- The column counter `c` (0..3) advances every `PHASE_CYCLES` clocks and wraps 3→0. `col` = ~(1<<c).
- Rows are sampled on the last clock of each phase. A low bit at row r means the key at (r, c) is pressed.
- Key layout by row (r), columns 0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
  - `key_code` is the hex value of the label.
- Scan result: after column 3 is sampled, the four samples classify as NONE (0 keys), ONE(k) (exactly 1 key), or MULTI (≥2 keys).
- State machine, evaluated once per completed scan:
  - RELEASED:
    - ONE(k) equal to the candidate → increment the match counter.
    - ONE(k) different from the candidate → candidate=k, counter=1.
    - On reaching `DEBOUNCE_SCANS`: go to HELD, `key_code`<=k, pulse `key_valid`, counter=0.
    - NONE or MULTI → counter=0.
  - HELD:
    - Any result other than ONE(`key_code`) increments the release counter.
    - ONE(`key_code`) clears the release counter.
    - On reaching `DEBOUNCE_SCANS`: go to RELEASED, counter=0.
    - A different key while HELD produces no press until release completes. No rollover.
- MULTI never produces a press (ghosting guard).
- Counters saturate and never wrap.

## Timing
- Reset values:
  - `col`=4'b1110, c=0, state RELEASED.
  - `key_code`=4'h0, `key_valid`=0, `key_held`=0.
  - All counters 0, synchronizer 4'hF.
- One scan lasts 4×`PHASE_CYCLES` clocks: 12 clocks (30 ms) at default.
- Press latency: a key stable before scan N starts gives `key_valid` high 1 clock after the last sample of scan N+`DEBOUNCE_SCANS`−1. That is at most (`DEBOUNCE_SCANS`+1) scans.
- `key_held` rises in the same cycle as `key_valid`. It falls 1 clock after the last sample of the `DEBOUNCE_SCANS`-th non-matching scan.
- `key_valid` is exactly 1 clock wide. There is no ready/backpressure; the consumer samples it every clock.
- Reset mid-scan: all state returns to reset values immediately and asynchronously. An in-flight debounce count is discarded.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a repeat counter counts completed ONE(`key_code`) scans.
  - Every `REPEAT_SCANS` scans, it pulses `key_valid` (same `key_code`) and restarts.
  - It is cleared on entry to HELD and by any non-matching scan.
- Not defined: repeat logic is absent. Exactly one `key_valid` per press.

## Test plan
- Reset, no keys pressed (`row`=4'hF) for 10 scans → `col` cycles 1110, 1101, 1011, 0111, each for 3 clocks; `key_valid` is never asserted; `key_code`=0.
- Hold key '5' (row1 low while col1 is driven) for 5 scans, then release → one `key_valid` pulse with `key_code`=4'h5 two scans after the press; `key_held` falls two scans after release.
- Bounce: toggle '9' every alternate scan for 6 scans → no `key_valid`; then hold '9' stable for 3 scans → a single pulse with `key_code`=4'h9.
- Press 'A' and 'D' together (row0 low on col3, row3 low on col3) for 6 scans → MULTI, no `key_valid`, `key_held`=0.
- Hold '0', then add '1' while held, release '0', and keep '1' held → only 4'h0 reported until a full release; assert `rst_n`=0 mid-scan → all outputs return to reset values within the same cycle.
- With `KEYPAD_REPEAT_EN`, hold 'F' for 20 scans → the first pulse after debounce, then pulses every 8 scans, all with `key_code`=4'hF.
